dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the byte-addressed data memory (synchronous read, 1-cycle read latency, size-coded accesses). It shares the single memory port between the core load/store unit (port 0) and the debug/loader master (port 1) using round-robin arbitration. It registers each accepted command and drives the memory enables for exactly one cycle. It also rejects illegal size/alignment combinations and returns read data with a valid pulse to the requester that was granted.

---
 rtl/dmem_arb_pkg.sv | 48 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: access size codes, FSM states,
// the registered command record and the size/alignment legality check.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  localparam logic [31:0] UART_STATUS_ADDR_DEF = 32'hFFFF_FFF8;

  // Control part of an accepted command; address and store data are kept
  // alongside it at the parameterised widths of the arbiter.
  typedef struct packed {
    logic       port;
    logic       we;
    logic [2:0] size;
    logic       err;
  } cmd_t;

  // Returns 1 when the access must be rejected without touching memory.
  function automatic logic cmd_illegal(input logic       we,
                                       input logic [2:0] size,
                                       input logic [1:0] alo,
                                       input logic       uart_hit);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = alo[0];
      SZ_W:    bad = (alo != 2'b00);
      SZ_BU:   bad = we;
      SZ_HU:   bad = we | alo[0];
      default: bad = 1'b1;
    endcase
    return bad | (we & uart_hit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, pointer flips only when
// both requesters contend while arbitration is enabled.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstN,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr <= 1'b0;
    end else if (en && (&req)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the data memory.
// Optional DMEM_ARB_PERF_EN adds saturating grant and conflict counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int                ADDR_W           = 32,
  parameter int                DATA_W           = 32,
  parameter logic [ADDR_W-1:0] UART_STATUS_ADDR = ADDR_W'(UART_STATUS_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              p0Req,
  input  logic              p0We,
  input  logic [ADDR_W-1:0] p0Addr,
  input  logic [2:0]        p0Size,
  input  logic [DATA_W-1:0] p0WData,
  output logic              p0Gnt,
  output logic              p0RValid,
  output logic [DATA_W-1:0] p0RData,
  output logic              p0Err,
  input  logic              p1Req,
  input  logic              p1We,
  input  logic [ADDR_W-1:0] p1Addr,
  input  logic [2:0]        p1Size,
  input  logic [DATA_W-1:0] p1WData,
  output logic              p1Gnt,
  output logic              p1RValid,
  output logic [DATA_W-1:0] p1RData,
  output logic              p1Err,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic [2:0]        memSize,
  output logic              memWEn,
  output logic              memREn,
  input  logic [DATA_W-1:0] memRData
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       p0GrantCnt,
  output logic [31:0]       p1GrantCnt,
  output logic [31:0]       conflictCnt
`endif
);

  state_e            state, nextState;
  cmd_t              cmd;
  logic [ADDR_W-1:0] cmdAddr;
  logic [DATA_W-1:0] cmdWData;

  logic              inIdle;
  logic [1:0]        req;
  logic [1:0]        arbGnt;
  logic [1:0]        gntIdle;
  logic              anyGnt;

  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [2:0]        selSize;
  logic [DATA_W-1:0] selWData;
  logic              selErr;

  always_comb begin
    inIdle  = (state == IDLE);
    req     = {p1Req, p0Req};
    gntIdle = inIdle ? arbGnt : 2'b00;
    anyGnt  = |gntIdle;
  end

  rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rstN (rstN),
    .req  (req),
    .en   (inIdle),
    .gnt  (arbGnt)
  );

  always_comb begin
    selWe    = gntIdle[1] ? p1We    : p0We;
    selAddr  = gntIdle[1] ? p1Addr  : p0Addr;
    selSize  = gntIdle[1] ? p1Size  : p0Size;
    selWData = gntIdle[1] ? p1WData : p0WData;
    selErr   = cmd_illegal(selWe, selSize, selAddr[1:0],
                           selAddr == UART_STATUS_ADDR);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Illegal commands skip ISSUE so memory never sees them.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyGnt) nextState = selErr ? RESP : ISSUE;
      ISSUE:   nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cmd      <= '0;
      cmdAddr  <= '0;
      cmdWData <= '0;
    end else if (anyGnt) begin
      cmd.port <= gntIdle[1];
      cmd.we   <= selWe;
      cmd.size <= selSize;
      cmd.err  <= selErr;
      cmdAddr  <= selAddr;
      cmdWData <= selWData;
    end
  end

  always_comb begin
    p0Gnt    = gntIdle[0];
    p1Gnt    = gntIdle[1];
    memAddr  = cmdAddr;
    memWData = cmdWData;
    memSize  = cmd.size;
    memWEn   = 1'b0;
    memREn   = 1'b0;
    p0RValid = 1'b0;
    p1RValid = 1'b0;
    p0Err    = 1'b0;
    p1Err    = 1'b0;
    p0RData  = '0;
    p1RData  = '0;
    case (state)
      ISSUE: begin
        memWEn = cmd.we;
        memREn = ~cmd.we;
      end
      RESP: begin
        if (cmd.port) begin
          p1RValid = 1'b1;
          p1Err    = cmd.err;
          p1RData  = (cmd.we || cmd.err) ? '0 : memRData;
        end else begin
          p0RValid = 1'b1;
          p0Err    = cmd.err;
          p0RData  = (cmd.we || cmd.err) ? '0 : memRData;
        end
      end
      default: ;
    endcase
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      p0GrantCnt  <= '0;
      p1GrantCnt  <= '0;
      conflictCnt <= '0;
    end else begin
      if (gntIdle[0] && (p0GrantCnt != '1)) p0GrantCnt <= p0GrantCnt + 32'd1;
      if (gntIdle[1] && (p1GrantCnt != '1)) p1GrantCnt <= p1GrantCnt + 32'd1;
      if (inIdle && (&req) && (conflictCnt != '1)) conflictCnt <= conflictCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a transaction-level reference model
// predicts grants, memory commands and responses cycle by cycle.
module tb_dmem_arbiter;

  localparam logic [31:0] UART = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic        rq     [0:1];
  logic        rwe    [0:1];
  logic [31:0] raddr  [0:1];
  logic [2:0]  rsize  [0:1];
  logic [31:0] rwdata [0:1];

  logic        p0Gnt, p1Gnt, p0RValid, p1RValid, p0Err, p1Err;
  logic [31:0] p0RData, p1RData;
  logic [31:0] memAddr, memWData, memRData;
  logic [2:0]  memSize;
  logic        memWEn, memREn;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] p0GrantCnt, p1GrantCnt, conflictCnt;
`endif

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .UART_STATUS_ADDR(UART)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .p0Req    (rq[0]),
    .p0We     (rwe[0]),
    .p0Addr   (raddr[0]),
    .p0Size   (rsize[0]),
    .p0WData  (rwdata[0]),
    .p0Gnt    (p0Gnt),
    .p0RValid (p0RValid),
    .p0RData  (p0RData),
    .p0Err    (p0Err),
    .p1Req    (rq[1]),
    .p1We     (rwe[1]),
    .p1Addr   (raddr[1]),
    .p1Size   (rsize[1]),
    .p1WData  (rwdata[1]),
    .p1Gnt    (p1Gnt),
    .p1RValid (p1RValid),
    .p1RData  (p1RData),
    .p1Err    (p1Err),
    .memAddr  (memAddr),
    .memWData (memWData),
    .memSize  (memSize),
    .memWEn   (memWEn),
    .memREn   (memREn),
    .memRData (memRData)
`ifdef DMEM_ARB_PERF_EN
    ,
    .p0GrantCnt  (p0GrantCnt),
    .p1GrantCnt  (p1GrantCnt),
    .conflictCnt (conflictCnt)
`endif
  );

  logic [7:0] devMem [0:1023];
  logic [7:0] refMem [0:1023];

  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] s);
    case (nbytes(s))
      1:       return s[2] ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2:       return s[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] raw;
    if (a == UART) return 32'h1;
    raw = '0;
    for (int i = 0; i < nbytes(s); i++) raw[8*i +: 8] = devMem[10'(a + 32'(i))];
    return extend(raw, s);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] raw;
    if (a == UART) return 32'h1;
    raw = '0;
    for (int i = 0; i < nbytes(s); i++) raw[8*i +: 8] = refMem[10'(a + 32'(i))];
    return extend(raw, s);
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] s, input logic [31:0] a);
    int n;
    n = nbytes(s);
    if (n == 0) return 1'b1;
    if (we && s[2]) return 1'b1;
    if ((a % 32'(n)) != 0) return 1'b1;
    if (we && a == UART) return 1'b1;
    return 1'b0;
  endfunction

  // Memory device stub: one-cycle read latency, junk on the bus otherwise.
  always @(posedge clk) begin
    if (memWEn)
      for (int i = 0; i < nbytes(memSize); i++)
        devMem[10'(memAddr + 32'(i))] <= memWData[8*i +: 8];
    if (memREn) memRData <= dev_read(memAddr, memSize);
    else        memRData <= $urandom;
  end

  int          nChecks = 0;
  int          nPass   = 0;
  int          cyc     = 0;
  int          freeCyc = 0;
  bit          pref    = 1'b0;
  bit          enPend  = 1'b0;
  int          enCyc;
  logic        enWe;
  logic [31:0] enAddr, enData;
  logic [2:0]  enSize;
  bit          rsPend  = 1'b0;
  int          rsCyc;
  int          rsPort;
  logic [31:0] rsData;
  logic        rsErr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Called at a falling edge with inputs already driven; advances one cycle.
  task automatic tick();
    bit   eEn, eV, g;
    int   w;
    logic err;
    #1;
    eEn = enPend && (enCyc == cyc);
    check("memREn", memREn, eEn && !enWe);
    check("memWEn", memWEn, eEn && enWe);
    if (eEn) begin
      check("memAddr", memAddr, enAddr);
      check("memSize", memSize, enSize);
      if (enWe) check("memWData", memWData, enData);
      enPend = 1'b0;
    end
    eV = rsPend && (rsCyc == cyc);
    check("p0RValid", p0RValid, eV && rsPort == 0);
    check("p1RValid", p1RValid, eV && rsPort == 1);
    if (eV) begin
      if (rsPort == 0) begin
        check("p0RData", p0RData, rsData);
        check("p0Err", p0Err, rsErr);
      end else begin
        check("p1RData", p1RData, rsData);
        check("p1Err", p1Err, rsErr);
      end
      rsPend = 1'b0;
    end
    g = 1'b0;
    w = 0;
    if (cyc >= freeCyc && (rq[0] || rq[1])) begin
      g = 1'b1;
      if (rq[0] && rq[1]) begin
        w = int'(pref);
        pref = !pref;
      end else begin
        w = rq[1] ? 1 : 0;
      end
    end
    check("p0Gnt", p0Gnt, g && w == 0);
    check("p1Gnt", p1Gnt, g && w == 1);
    if (g) begin
      err    = ref_err(rwe[w], rsize[w], raddr[w]);
      rsPend = 1'b1;
      rsPort = w;
      rsErr  = err;
      if (err) begin
        rsCyc   = cyc + 1;
        freeCyc = cyc + 2;
        rsData  = '0;
      end else begin
        enPend  = 1'b1;
        enCyc   = cyc + 1;
        enWe    = rwe[w];
        enAddr  = raddr[w];
        enSize  = rsize[w];
        enData  = rwdata[w];
        rsCyc   = cyc + 2;
        freeCyc = cyc + 3;
        if (rwe[w]) begin
          for (int i = 0; i < nbytes(rsize[w]); i++)
            refMem[10'(raddr[w] + 32'(i))] = rwdata[w][8*i +: 8];
          rsData = '0;
        end else begin
          rsData = ref_read(raddr[w], rsize[w]);
        end
      end
    end
    @(posedge clk);
    #1;
    if (g) rq[w] = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input int p, input logic we, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] d);
    rq[p]     = 1'b1;
    rwe[p]    = we;
    raddr[p]  = a;
    rsize[p]  = s;
    rwdata[p] = d;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (!rq[0] && !rq[1] && !enPend && !rsPend && cyc >= freeCyc) done = 1'b1;
      else tick();
    end
    if (!done) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic rand_req(input int p);
    logic [2:0]  s;
    logic [31:0] a;
    int          n;
    if ($urandom_range(0, 7) == 0) s = 3'($urandom_range(0, 7));
    else case ($urandom_range(0, 4))
      0: s = 3'd0; 1: s = 3'd1; 2: s = 3'd2; 3: s = 3'd4; default: s = 3'd5;
    endcase
    if ($urandom_range(0, 9) == 0) a = UART;
    else a = 32'($urandom_range(0, 1020));
    n = nbytes(s);
    if (n > 0 && $urandom_range(0, 9) < 7) a = a & ~(32'(n) - 32'd1);
    drive(p, 1'($urandom_range(0, 1)), a, s, $urandom);
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      devMem[i] = b;
      refMem[i] = b;
    end
    devMem[256] = 8'h44; devMem[257] = 8'h33; devMem[258] = 8'h22; devMem[259] = 8'h11;
    refMem[256] = 8'h44; refMem[257] = 8'h33; refMem[258] = 8'h22; refMem[259] = 8'h11;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = '0; rsize[p] = '0; rwdata[p] = '0;
    end

    repeat (2) @(negedge clk);
    #1;
    check("rst_p0Gnt", p0Gnt, 0);
    check("rst_p1Gnt", p1Gnt, 0);
    check("rst_p0RValid", p0RValid, 0);
    check("rst_p1RValid", p1RValid, 0);
    check("rst_p0Err", p0Err, 0);
    check("rst_p1Err", p1Err, 0);
    check("rst_p0RData", p0RData, 0);
    check("rst_p1RData", p1RData, 0);
    check("rst_memWEn", memWEn, 0);
    check("rst_memREn", memREn, 0);
    check("rst_memAddr", memAddr, 0);
    check("rst_memWData", memWData, 0);
    check("rst_memSize", memSize, 0);
    @(negedge clk);
    rstN = 1'b1;

    drive(0, 1'b0, 32'h100, 3'd2, '0);
    drain();

    drive(0, 1'b0, 32'h100, 3'd2, '0);
    drive(1, 1'b0, 32'h104, 3'd2, '0);
    drain();
    for (int k = 0; k < 13; k++) begin
      if (!rq[0]) drive(0, 1'b0, 32'h100, 3'd2, '0);
      if (!rq[1]) drive(1, 1'b0, 32'h104, 3'd2, '0);
      tick();
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    drain();

    drive(1, 1'b1, 32'h202, 3'd1, 32'h0000_BEEF); drain();
    drive(1, 1'b0, 32'h202, 3'd5, '0);            drain();
    drive(1, 1'b0, 32'h202, 3'd1, '0);            drain();
    drive(0, 1'b0, 32'h101, 3'd2, '0);            drain();
    drive(0, 1'b1, UART, 3'd2, 32'h1234_5678);    drain();
    drive(0, 1'b0, UART, 3'd2, '0);               drain();

    // Reset during ISSUE: enables and completion must vanish immediately.
    drive(0, 1'b0, 32'h100, 3'd2, '0);
    for (int k = 0; k < 10 && !(enPend && enCyc == cyc); k++) tick();
    check("reached_issue", 32'(enPend && enCyc == cyc), 32'd1);
    #1;
    check("issue_memREn", memREn, 1);
    rstN = 1'b0;
    #1;
    check("rstmid_memREn", memREn, 0);
    check("rstmid_memWEn", memWEn, 0);
    check("rstmid_p0RValid", p0RValid, 0);
    @(posedge clk);
    #1;
    check("rstmid_noresp", p0RValid, 0);
    @(negedge clk);
    rstN = 1'b1;
    cyc++;
    enPend = 1'b0; rsPend = 1'b0; pref = 1'b0; freeCyc = cyc;
    drive(0, 1'b0, 32'h100, 3'd2, '0);
    drive(1, 1'b0, 32'h104, 3'd2, '0);
    drain();

    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++)
        if (!rq[p] && $urandom_range(0, 2) == 0) rand_req(p);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
